seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.
//   Consumes the 4-bit digit values produced by the digit-entry counters and the result logic.
//   Latches a full frame atomically so that a digit changing mid-scan never produces a torn image.
//   Drives active-low anodes, segments and decimal point directly to the pins.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20
//   LZ_BLANK_EN  1       1 = leading-zero blanking is honoured when blank_lz=1; 0 = never blank
// PORTS
//   clk       in   1   system clock
//   rst       in   1   synchronous, active-high reset
//   digits    in   16  {d3,d2,d1,d0}, 4 bits each; d0 = rightmost digit
//   dp_in     in   4   decimal point request per digit, bit i = digit i, active-high
//   blank_lz  in   1   request leading-zero blanking
//   an        out  4   anode enables, active-low, an[i] = digit i
//   seg       out  7   {g,f,e,d,c,b,a}, active-low
//   dp        out  1   decimal point, active-low
// BEHAVIOUR
//   Reset: div_cnt=0, slot=0, shadow regs=0, an=4'b1111, seg=7'b1111111, dp=1.
//   div_cnt counts 0..REFRESH_DIV-1 and wraps; on the wrap, slot advances 0->1->2->3->0.
//   Frame start = (div_cnt==0 && slot==0); includes the first cycle with rst low.
//   At frame start: shadow_digits<=digits, shadow_dp<=dp_in, shadow_lz<=blank_lz&LZ_BLANK_EN.
//   Inputs are ignored at all other times; a change becomes visible only after the next frame start.
//   Outputs are registered from slot + shadow: each output changes 1 cycle after its slot/shadow change.
//   After rst falls, edge 1 loads shadow, edge 2 presents slot 0 on an/seg/dp.
//   an = ~(4'b0001 << slot) unless the slot is blanked; a blanked slot drives an=4'b1111, seg=7'b1111111, dp=1.
//   Leading-zero blank: when shadow_lz=1, digit i (i=3..1) is blanked if d_i==0 and all d_j (j>i) are 0.
//   Digit 0 is never blanked. A digit's dp request is also suppressed when that digit is blanked.
//   Decode (active-low, {g..a}):
//     0:1000000 1:1111001 2:0100100 3:0110000 4:0011001
//     5:0010010 6:0000010 7:1111000 8:0000000 9:0010000
//     4'hA: '-' 0111111   4'hB..4'hE: 'E' 0000110   4'hF: blank 1111111 (an still asserted)
//   Code 4'hA / 4'hF never count as zero for leading-zero blanking.
//   dp = ~shadow_dp[slot] for a non-blanked slot.
//   Reset mid-frame: all state returns to reset values on the same edge; scanning restarts at slot 0.
//   No combinational path from any input to any output.
// TESTING (bench uses REFRESH_DIV=4)
//   1 Hold rst 3 cycles -> an=1111, seg=1111111, dp=1 on every cycle of reset.
//   2 digits=16'h0127, dp_in=0, release rst -> 2nd edge: an=1110 seg=1111000 ('7').
//     Then 4 cycles each: an=1101 seg=0100100, an=1011 seg=1111001, an=0111 seg=1000000, then back to 1110.
//   3 digits=16'h0042, blank_lz=1 -> slots 3,2 an=1111 seg=1111111; slot1 '4' 0011001; slot0 '2' 0100100.
//     Same with digits=16'h0000 -> only slot 0 shows '0' 1000000.
//   4 Change digits 16'h1111->16'h8888 while slot=1 -> slots 1..3 still show '1' 1111001.
//     '8' 0000000 first appears 1 cycle after the next frame start.
//   5 digits=16'hAFB3, dp_in=4'b0010 -> slot3 '-' 0111111.
//     slot2 an=1011 seg=1111111; slot1 'E' 0000110 dp=0; slot0 '3' 0110000 dp=1.
//   6 Assert rst for 1 cycle while slot=2 -> next edge an=1111.
//     Two edges after release, slot 0 is shown with the digits value present at the release.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A full frame of digit values is latched atomically at the start of each scan so a
// digit changing mid-scan never produces a torn image. All outputs are registered.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,  // clk cycles per digit slot, 2..2^20
  parameter bit          LZ_BLANK_EN = 1'b1     // 0 = ignore blank_lz entirely
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic [15:0]     shadow_digits_q, shadow_digits_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic            shadow_lz_q, shadow_lz_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            wrap;
  logic            frame_start;
  logic [3:0]      is_zero;
  logic [3:0]      blank_mask;
  logic [3:0]      cur_digit;
  logic [6:0]      cur_seg;

  // Slot timing, frame latch, blanking and decode for the registered outputs.
  always_comb begin
    wrap        = (div_cnt_q == CntLast);
    frame_start = (div_cnt_q == '0) && (slot_q == 2'd0);

    div_cnt_d = wrap ? '0 : div_cnt_q + CntW'(1);
    slot_d    = wrap ? slot_q + 2'd1 : slot_q;

    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_lz_d     = shadow_lz_q;
    if (frame_start) begin
      shadow_digits_d = digits;
      shadow_dp_d     = dp_in;
      shadow_lz_d     = blank_lz & LZ_BLANK_EN;
    end

    // Only a true 0 counts as zero; '-' (A) and blank (F) stop leading-zero blanking.
    for (int i = 0; i < 4; i++) begin
      is_zero[i] = (shadow_digits_q[4*i +: 4] == 4'h0);
    end
    blank_mask[3] = shadow_lz_q & is_zero[3];
    blank_mask[2] = shadow_lz_q & is_zero[3] & is_zero[2];
    blank_mask[1] = shadow_lz_q & is_zero[3] & is_zero[2] & is_zero[1];
    blank_mask[0] = 1'b0;

    cur_digit = shadow_digits_q[4*slot_q +: 4];
    unique case (cur_digit)
      4'h0:    cur_seg = 7'b1000000;
      4'h1:    cur_seg = 7'b1111001;
      4'h2:    cur_seg = 7'b0100100;
      4'h3:    cur_seg = 7'b0110000;
      4'h4:    cur_seg = 7'b0011001;
      4'h5:    cur_seg = 7'b0010010;
      4'h6:    cur_seg = 7'b0000010;
      4'h7:    cur_seg = 7'b1111000;
      4'h8:    cur_seg = 7'b0000000;
      4'h9:    cur_seg = 7'b0010000;
      4'hA:    cur_seg = 7'b0111111;
      4'hF:    cur_seg = 7'b1111111;
      default: cur_seg = 7'b0000110;  // B..E shown as 'E'
    endcase

    if (blank_mask[slot_q]) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << slot_q);
      seg_d = cur_seg;
      dp_d  = ~shadow_dp_q[slot_q];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q       <= '0;
      slot_q          <= 2'd0;
      shadow_digits_q <= 16'h0000;
      shadow_dp_q     <= 4'h0;
      shadow_lz_q     <= 1'b0;
      an_q            <= 4'b1111;
      seg_q           <= 7'b1111111;
      dp_q            <= 1'b1;
    end else begin
      div_cnt_q       <= div_cnt_d;
      slot_q          <= slot_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_lz_q     <= shadow_lz_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 4-cycle digit slot.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(
    .REFRESH_DIV(4),
    .LZ_BLANK_EN(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .digits  (digits),
    .dp_in   (dp_in),
    .blank_lz(blank_lz),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // One frame stimulus plus the expected picture of every slot.
  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz;
    logic [3:0]  blank;  // slot i blanked -> an=1111
    logic [27:0] segs;   // {s3,s2,s1,s0}
    logic [3:0]  dps;    // expected dp pin per slot
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    exp_t e;
    e.an  = e_an;
    e.seg = e_seg;
    e.dp  = e_dp;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: nothing expected queued, got an=%b seg=%b dp=%b", name, an, seg, dp);
    end else begin
      e = sb.pop_front();
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        n_bad++;
        $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 name, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  // Reset, release, then check edges 2..16 of the first frame.
  task automatic run_vec(input vec_t v, input int idx);
    int s;
    logic [3:0] e_an;
    rst      = 1'b1;
    digits   = v.digits;
    dp_in    = v.dp_in;
    blank_lz = v.lz;
    push(4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    check($sformatf("vec%0d_reset", idx));
    rst = 1'b0;
    @(negedge clk);  // edge 1: shadow load
    for (int k = 2; k <= 16; k++) begin
      s    = (k - 1) / 4;
      e_an = v.blank[s] ? 4'b1111 : ~(4'b0001 << s);
      push(e_an, v.segs[s*7 +: 7], v.dps[s]);
      @(negedge clk);
      check($sformatf("vec%0d_edge%0d_slot%0d", idx, k, s));
    end
  endtask

  initial begin
    int s;
    rst      = 1'b1;
    digits   = 16'h0000;
    dp_in    = 4'h0;
    blank_lz = 1'b0;

    //           digits    dp_in  lz    blank    s3         s2         s1         s0      dps
    vecs[0] = '{16'h0127, 4'b0000, 1'b0, 4'b0000,
                {7'b1000000, 7'b1111001, 7'b0100100, 7'b1111000}, 4'b1111};
    vecs[1] = '{16'h0042, 4'b1111, 1'b1, 4'b1100,
                {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}, 4'b1100};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b1110,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'hAFB3, 4'b0010, 1'b0, 4'b0000,
                {7'b0111111, 7'b1111111, 7'b0000110, 7'b0110000}, 4'b1101};
    vecs[4] = '{16'h0305, 4'b0101, 1'b1, 4'b1000,
                {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}, 4'b1010};
    vecs[5] = '{16'h5689, 4'b1000, 1'b1, 4'b0000,
                {7'b0010010, 7'b0000010, 7'b0000000, 7'b0010000}, 4'b0111};
    vecs[6] = '{16'h0A00, 4'b0000, 1'b1, 4'b1000,
                {7'b1111111, 7'b0111111, 7'b1000000, 7'b1000000}, 4'b1111};
    vecs[7] = '{16'hFC0D, 4'b0000, 1'b1, 4'b0000,
                {7'b1111111, 7'b0000110, 7'b1000000, 7'b0000110}, 4'b1111};
    vecs[8] = '{16'h0F00, 4'b0100, 1'b1, 4'b1000,
                {7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000}, 4'b1011};
    vecs[9] = '{16'h0000, 4'b1111, 1'b0, 4'b0000,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};

    // Outputs idle on every cycle of a 3-cycle reset.
    for (int i = 0; i < 3; i++) begin
      push(4'b1111, 7'b1111111, 1'b1);
      @(negedge clk);
      check($sformatf("init_reset%0d", i));
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Input change mid-frame stays invisible until the next frame latch.
    rst      = 1'b1;
    digits   = 16'h1111;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    digits = 16'h8888;  // slot 1 is being scanned
    for (int k = 6; k <= 17; k++) begin
      s = ((k - 1) / 4) % 4;
      push(~(4'b0001 << s), 7'b1111001, 1'b1);
      @(negedge clk);
      check($sformatf("torn_edge%0d", k));
    end
    push(4'b1110, 7'b0000000, 1'b1);
    @(negedge clk);
    check("torn_new_frame");

    // One-cycle reset while slot 2 is on screen.
    rst    = 1'b1;
    digits = 16'h1234;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    push(4'b1011, 7'b0100100, 1'b1);
    @(negedge clk);
    check("midrst_slot2");
    rst    = 1'b1;
    digits = 16'h5555;
    push(4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    check("midrst_idle");
    rst    = 1'b0;
    digits = 16'h0006;
    @(negedge clk);
    digits = 16'h0009;  // after the latch edge, must not appear
    push(4'b1110, 7'b0000010, 1'b1);
    @(negedge clk);
    check("midrst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
